tile_board_display: RTL
=======================

# tile_board_display

Parametrised board renderer and cursor controller for the MineSweeper VGA path. It sits between the VGA timing generator and the game logic. Per pixel, it maps coordinates to a tile index, fetches tile status from game memory, and outputs the tile colour, cursor highlight or background colour. Once per frame, it moves a bounded cursor with hold-to-repeat, and it issues reveal/flag requests to the game logic over a valid/ready handshake.

## Interface
Parameters:
- COLS, 5: board columns.
- ROWS, 5: board rows.
- TILE_SHIFT, 6: log2 of tile edge in pixels (64 px).
- ORG_X, 1: board origin in tile units.
- ORG_Y, 1: board origin in tile units.
- STATUS_W, 4: tile status width.
- BPC, 12: bits per colour.
- REPEAT_DELAY, 20: frames held before auto-repeat starts.
- REPEAT_PERIOD, 6: frames between repeats.

Ports (IDW = $clog2(COLS*ROWS)):
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- pix_en  in  1  one-clk pixel strobe (25 MHz).
- active  in  1  timing-generator active-video flag.
- frame_end  in  1  screenEnd; level, edge-detected internally.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- x  in  10  pixel column.
- y  in  9  pixel row.
- bg_color  in  BPC  background colour, aligned to output stage.
- tile_addr  out  IDW  status read address.
- tile_status  in  STATUS_W  synchronous-RAM data, valid 1 clk after tile_addr.
- btn_up, btn_down, btn_left, btn_right, btn_sel, btn_flag  in  1 each  raw async buttons.
- clear  in  1  request abort (pr_reset).
- rgb  out  BPC  pixel colour.
- hsync  out  1  delayed sync.
- vsync  out  1  delayed sync.
- cursor_id  out  IDW  row*COLS+col of cursor.
- req_valid  out  1  request handshake valid.
- req_flag  out  1  1 = flag, 0 = reveal.
- req_id  out  IDW  tile index of the request.
- req_ready  in  1  request handshake ready.

## Operation
- Reset values: cursor (0,0), cursor_id 0, rgb 0, hsync/vsync 1, tile_addr 0, req_valid/req_flag/req_id 0, move FSM IDLE.
- Tile decode:
  - tx = (x>>TILE_SHIFT) - ORG_X; ty = (y>>TILE_SHIFT) - ORG_Y, computed unsigned at 10 bits.
  - in_board = tx<COLS && ty<ROWS; underflow wraps large and so reads as outside.
  - tile_addr = ty*COLS+tx when in_board, else held.
- Colour, in priority order:
  - !active → 0;
  - in_board && tile==cursor → 12'h777;
  - in_board → STATUS_COLOR[tile_status];
  - else bg_color.
- STATUS_COLOR for 0..11: fff, 770, 0f0, 00f, 700, 070, 007, ff0, 0ff, f00, 000, 000. Status ≥12 → 000.
- Buttons: all pass through a 2-FF synchroniser. sel/flag are rising-edge detected in clk.
- Move FSM, evaluated only on the frame_end rising edge:
  - IDLE: any direction held → step, HOLD, cnt=0.
  - HOLD: cnt==REPEAT_DELAY-1 → step, REPEAT, cnt=0; else cnt++.
  - REPEAT: cnt==REPEAT_PERIOD-1 → step, cnt=0; else cnt++.
  - Any state: no direction held → IDLE.
  - Step: each axis moves ±1. Opposite buttons on one axis cancel; diagonals allowed.
  - Step saturates at 0 and COLS-1 / ROWS-1 (no wrap).
- Request handshake:
  - sel or flag edge while !req_valid and !blocked → req_valid=1, req_id=cursor_id, req_flag=flag edge && !sel edge (sel wins on a tie).
  - Outputs are held stable until req_valid && req_ready; req_valid drops the next clk.
  - Edges arriving while req_valid is high are dropped. Cursor movement does not alter req_id.
- clear: forces req_valid=0 the next clk and sets blocked. blocked clears when clear, sel and flag are all low.

## Timing
- Pixel pipeline, two pix_en stages:
  - S1 on pix_en N: register tile_addr, in_board, is_cursor, active, syncs.
  - S2 on pix_en N+1: register rgb/hsync/vsync from tile_status, which has been valid since 1 clk after S1.
  - rgb/hsync/vsync lag x/y/sync inputs by exactly 2 pix_en. Registers hold between strobes.
- cursor_id updates 1 clk after the frame_end rising edge. Because frame_end falls between frames, no visible pixel ever sees a mid-frame cursor change.
- Button to request: req_valid rises 3 clk after the raw edge (2 sync + 1 edge).
- Handshake: ready may be high before valid; a transfer completes on any clk where both are high.
- Asynchronous reset mid-frame or mid-request returns everything to reset values immediately; no request is replayed.

## Structure
- Package vga_tile_pkg holds:
  - STATUS_COLOR array;
  - CURSOR_COLOR;
  - move FSM state encoding (IDLE, HOLD, REPEAT);
  - index-width function.
- Sub-module button_conditioner, one instance per button: 2-FF synchroniser, with level and rising-edge outputs.

## Test plan
- Reset, then x=64,y=64, active=1, tile_status=3 → after 2 pix_en rgb=777 (cursor at tile 0). Move cursor away → rgb=00f.
- btn_right held 1 frame from (0,0) → cursor_id=1. Held 40 frames with defaults → steps at frames 0, 20, 26, 32, 38; saturates at col 4 (cursor_id=4).
- btn_left+btn_right+btn_down together at (2,2) → cursor (2,3), cursor_id=17. btn_up at row 0 → unchanged.
- btn_sel and btn_flag edges in the same clk at cursor 7, req_ready=0 for 10 clk → req_valid=1, req_flag=0, req_id=7 held. Second sel edge ignored. req_ready=1 → req_valid=0 next clk.
- clear during a pending request with btn_sel held → req_valid=0. No new request until btn_sel is released and pressed again.
- x=0,y=0 and x=400,y=300 (outside board) → rgb=bg_color. active=0 → rgb=0. tile_status=13 on board → rgb=000.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// Shared constants and types for the tile board renderer: palette, cursor colour,
// cursor-move FSM encoding and the index-width helper.
package vga_tile_pkg;

  localparam logic [11:0] CURSOR_COLOR = 12'h777;

  localparam logic [11:0] STATUS_COLOR [12] = '{
    12'hfff, 12'h770, 12'h0f0, 12'h00f, 12'h700, 12'h070,
    12'h007, 12'hff0, 12'h0ff, 12'hf00, 12'h000, 12'h000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } move_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Codes outside the palette render black rather than aliasing into it.
  function automatic logic [11:0] status_color(input logic [31:0] s);
    if (s < 32'd12) return STATUS_COLOR[s[3:0]];
    return 12'h000;
  endfunction

endpackage

// File: rtl/tile_board_display_if.sv
// Reveal/flag request channel from the board display to the game logic.
interface tile_board_display_if #(
  parameter int IDW = 5
);
  logic           req_valid;
  logic           req_flag;
  logic [IDW-1:0] req_id;
  logic           req_ready;

  modport master (output req_valid, output req_flag, output req_id, input req_ready);
  modport slave  (input req_valid, input req_flag, input req_id, output req_ready);
endinterface

// File: rtl/button_conditioner.sv
// Two-flop synchroniser for a raw push button, with level and rising-edge outputs.
module button_conditioner (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], raw};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];

endmodule

// File: rtl/tile_board_display.sv
// Board renderer and cursor controller: pixel-to-tile pipeline, frame-rate cursor
// movement with hold-to-repeat, and reveal/flag request issue.
//   state  | meaning
//   IDLE   | no direction held
//   HOLD   | first step taken, counting toward auto-repeat
//   REPEAT | auto-repeating every REPEAT_PERIOD frames
module tile_board_display
  import vga_tile_pkg::*;
#(
  parameter int COLS          = 5,
  parameter int ROWS          = 5,
  parameter int TILE_SHIFT    = 6,
  parameter int ORG_X         = 1,
  parameter int ORG_Y         = 1,
  parameter int STATUS_W      = 4,
  parameter int BPC           = 12,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 6,
  localparam int IDW          = idx_w(COLS * ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_en,
  input  logic                active,
  input  logic                frame_end,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [9:0]          x,
  input  logic [8:0]          y,
  input  logic [BPC-1:0]      bg_color,
  output logic [IDW-1:0]      tile_addr,
  input  logic [STATUS_W-1:0] tile_status,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_sel,
  input  logic                btn_flag,
  input  logic                clear,
  output logic [BPC-1:0]      rgb,
  output logic                hsync,
  output logic                vsync,
  output logic [IDW-1:0]      cursor_id,
  tile_board_display_if.master req
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [5:0] btn_raw, btn_lvl, btn_rise;
  logic       unused_dir_rise;

  assign btn_raw = {btn_flag, btn_sel, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 6; i++) begin : g_btn
    button_conditioner u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  assign unused_dir_rise = ^btn_rise[3:0];

  logic up_l, down_l, left_l, right_l, sel_l, flag_l, sel_r, flag_r;
  assign {flag_l, sel_l, right_l, left_l, down_l, up_l} = btn_lvl;
  assign sel_r  = btn_rise[4];
  assign flag_r = btn_rise[5];

  logic [9:0] cur_col, cur_row, col_n, row_n;
  logic [9:0] tx, ty;
  logic       in_board, is_cursor;

  assign tx        = (x >> TILE_SHIFT) - 10'(ORG_X);
  assign ty        = ({1'b0, y} >> TILE_SHIFT) - 10'(ORG_Y);
  assign in_board  = (tx < 10'(COLS)) && (ty < 10'(ROWS));
  assign is_cursor = in_board && (tx == cur_col) && (ty == cur_row);
  assign cursor_id = IDW'(cur_row * 10'(COLS) + cur_col);

  logic           s1_in_board, s1_cursor, s1_active, s1_hs, s1_vs;
  logic [BPC-1:0] pix_color;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_addr   <= '0;
      s1_in_board <= 1'b0;
      s1_cursor   <= 1'b0;
      s1_active   <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
    end else if (pix_en) begin
      if (in_board) tile_addr <= IDW'(ty * 10'(COLS) + tx);
      s1_in_board <= in_board;
      s1_cursor   <= is_cursor;
      s1_active   <= active;
      s1_hs       <= hsync_in;
      s1_vs       <= vsync_in;
    end
  end

  always_comb begin
    pix_color = bg_color;
    if (!s1_active)                    pix_color = '0;
    else if (s1_in_board && s1_cursor) pix_color = BPC'(CURSOR_COLOR);
    else if (s1_in_board)              pix_color = BPC'(status_color(32'(tile_status)));
  end

  // tile_status answers the S1 address one clk later, so it is settled by the next strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb   <= pix_color;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  end

  move_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fe_q, fe_rise, dir_any, do_step;

  assign fe_rise = frame_end & ~fe_q;
  assign dir_any = up_l | down_l | left_l | right_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_q    <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      fe_q    <= frame_end;
      state   <= state_n;
      cnt     <= cnt_n;
      cur_col <= col_n;
      cur_row <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    do_step = 1'b0;
    col_n   = cur_col;
    row_n   = cur_row;
    if (fe_rise) begin
      if (!dir_any) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        case (state)
          IDLE: begin
            do_step = 1'b1;
            state_n = HOLD;
            cnt_n   = '0;
          end
          HOLD: begin
            if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
              do_step = 1'b1;
              state_n = REPEAT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
              do_step = 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
    if (do_step) begin
      if (right_l && !left_l && cur_col != 10'(COLS - 1)) col_n = cur_col + 10'd1;
      else if (left_l && !right_l && cur_col != 10'd0)    col_n = cur_col - 10'd1;
      if (down_l && !up_l && cur_row != 10'(ROWS - 1))    row_n = cur_row + 10'd1;
      else if (up_l && !down_l && cur_row != 10'd0)       row_n = cur_row - 10'd1;
    end
  end

  logic           valid_q, flag_q, blocked;
  logic [IDW-1:0] id_q;

  // blocked stops a button still held across a clear from re-issuing the aborted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      id_q    <= '0;
      blocked <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      blocked <= 1'b1;
    end else begin
      if (blocked && !sel_l && !flag_l) blocked <= 1'b0;
      if (valid_q) begin
        if (req.req_ready) valid_q <= 1'b0;
      end else if ((sel_r || flag_r) && !blocked) begin
        valid_q <= 1'b1;
        id_q    <= cursor_id;
        flag_q  <= flag_r && !sel_r;
      end
    end
  end

  assign req.req_valid = valid_q;
  assign req.req_flag  = flag_q;
  assign req.req_id    = id_q;

endmodule
